// File: rtl/stream_rr_arbiter.sv
// Packet-aware round-robin merge of N valid/ready streams into one, with a zero-cycle data path.
// A source that starts a multi-beat packet keeps the grant until its last beat transfers.
module stream_rr_arbiter #(
    parameter int N_INPUTS   = 4,
    parameter int DATA_WIDTH = 16,
    parameter int SRC_WIDTH  = 2
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [N_INPUTS-1:0]            in_valid,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [N_INPUTS-1:0]            in_last,
    output logic [N_INPUTS-1:0]            in_ready,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_last,
    output logic [SRC_WIDTH-1:0]           out_src,
    input  logic                           out_ready
);

    localparam int EW = SRC_WIDTH + 1;
    localparam logic [EW-1:0] N_EXT = EW'(N_INPUTS);
    localparam logic [SRC_WIDTH-1:0] LAST_IDX = SRC_WIDTH'(N_INPUTS - 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SRC_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SRC_WIDTH-1:0]   lock_src_q, lock_src_d;

    logic [SRC_WIDTH-1:0]   cand_idx [N_INPUTS];
    logic [N_INPUTS-1:0]    cand_vld;
    logic [DATA_WIDTH-1:0]  data_arr [N_INPUTS];
    logic [SRC_WIDTH-1:0]   scan_grant;
    logic [SRC_WIDTH-1:0]   grant;
    logic                   sel_valid;
    logic                   sel_last;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   xfer;

    // Candidate gi is the source gi positions after rr_ptr, wrapped at N_INPUTS.
    generate
        for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_cand
            logic [EW-1:0] sum;
            assign sum           = {1'b0, rr_ptr_q} + EW'(gi);
            assign cand_idx[gi]  = (sum >= N_EXT) ? SRC_WIDTH'(sum - N_EXT) : sum[SRC_WIDTH-1:0];
            assign cand_vld[gi]  = in_valid[cand_idx[gi]];
            assign data_arr[gi]  = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign in_ready[gi]  = reset_n && out_ready && (grant == SRC_WIDTH'(gi));
        end
    endgenerate

    always_comb begin
        scan_grant = rr_ptr_q;
        for (int k = N_INPUTS - 1; k >= 0; k--) begin
            if (cand_vld[k]) begin
                scan_grant = cand_idx[k];
            end
        end
        grant = (state_q == LOCKED) ? lock_src_q : scan_grant;
    end

    assign sel_valid = in_valid[grant];
    assign sel_last  = in_last[grant];
    assign sel_data  = data_arr[grant];

    assign out_valid = reset_n && sel_valid;
    assign out_data  = out_valid ? sel_data : '0;
    assign out_last  = out_valid && sel_last;
    assign out_src   = reset_n ? grant : '0;
    assign xfer      = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_src_d = lock_src_q;
        if (xfer) begin
            if (out_last) begin
                state_d  = UNLOCKED;
                rr_ptr_d = (grant == LAST_IDX) ? '0 : grant + 1'b1;
            end else begin
                state_d    = LOCKED;
                lock_src_d = grant;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= UNLOCKED;
            rr_ptr_q   <= '0;
            lock_src_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_src_q <= lock_src_d;
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed checks of stream_rr_arbiter: a per-cycle vector table plus hand-written
// backpressure and wrap/skip scoreboard sequences.
module tb_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int SW = 2;
    localparam int NV = 24;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [N-1:0]      in_valid;
    logic [N*DW-1:0]   in_data;
    logic [N-1:0]      in_last;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic [SW-1:0]     out_src;
    logic              out_ready;

    int total = 0;
    int bad   = 0;

    stream_rr_arbiter #(.N_INPUTS(N), .DATA_WIDTH(DW), .SRC_WIDTH(SW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         rst_n;
        logic [3:0]   v;
        logic [3:0]   l;
        logic         rdy;
        logic         e_ov;
        logic [1:0]   e_src;
        logic         e_last;
        logic [3:0]   e_ird;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_data(input logic [15:0] base);
        for (int i = 0; i < N; i++) begin
            in_data[i*DW +: DW] = base | 16'(i);
        end
    endtask

    logic [15:0] base;
    logic [15:0] exp_data;
    int          xf;
    logic [15:0] s0 [2];
    logic [15:0] s3 [2];
    logic [15:0] q0 [$];
    logic [15:0] q3 [$];
    logic [1:0]  exp_order [4];
    int          p0, p3, received;

    initial begin
        reset_n   = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b0;

        //          rst   valid    last     rdy   ov    src   last  in_ready
        vecs[0]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
        vecs[1]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
        vecs[2]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001};
        vecs[3]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010};
        vecs[4]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100};
        vecs[5]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000};
        vecs[6]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001};
        vecs[7]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010};
        vecs[8]  = '{1'b1, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001};
        vecs[9]  = '{1'b1, 4'b0111, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0, 4'b0010};
        vecs[10] = '{1'b1, 4'b0111, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0, 4'b0010};
        vecs[11] = '{1'b1, 4'b0111, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010};
        vecs[12] = '{1'b1, 4'b0101, 4'b0101, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100};
        vecs[13] = '{1'b1, 4'b1000, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b0, 4'b1000};
        vecs[14] = '{1'b1, 4'b0111, 4'b0111, 1'b1, 1'b0, 2'd3, 1'b0, 4'b1000};
        vecs[15] = '{1'b1, 4'b0111, 4'b0111, 1'b1, 1'b0, 2'd3, 1'b0, 4'b1000};
        vecs[16] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000};
        vecs[17] = '{1'b1, 4'b0110, 4'b0110, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010};
        vecs[18] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0100};
        vecs[19] = '{1'b1, 4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0, 4'b0010};
        vecs[20] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
        vecs[21] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001};
        vecs[22] = '{1'b1, 4'b0100, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0000};
        vecs[23] = '{1'b1, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100};

        for (int r = 0; r < NV; r++) begin
            @(negedge clock);
            reset_n   = vecs[r].rst_n;
            in_valid  = vecs[r].v;
            in_last   = vecs[r].l;
            out_ready = vecs[r].rdy;
            base      = {8'(r), 8'h00};
            set_data(base);
            #2;
            exp_data = vecs[r].e_ov ? (base | 16'(vecs[r].e_src)) : 16'h0000;
            $display("vec %0d: valid=%b rdy=%b -> ov=%b src=%0d last=%b data=%h in_ready=%b",
                     r, in_valid, out_ready, out_valid, out_src, out_last, out_data, in_ready);
            check($sformatf("v%0d out_valid", r), 32'(out_valid), 32'(vecs[r].e_ov));
            check($sformatf("v%0d out_src", r),   32'(out_src),   32'(vecs[r].e_src));
            check($sformatf("v%0d out_last", r),  32'(out_last),  32'(vecs[r].e_last));
            check($sformatf("v%0d in_ready", r),  32'(in_ready),  32'(vecs[r].e_ird));
            check($sformatf("v%0d out_data", r),  32'(out_data),  32'(exp_data));
        end

        // Backpressure: rr_ptr is 3 here, so src1 wins the scan 3,0,1.
        @(negedge clock);
        in_data   = '0;
        in_data[1*DW +: DW] = 16'hBEEF;
        in_valid  = 4'b0010;
        in_last   = 4'b0010;
        out_ready = 1'b0;
        xf = 0;
        for (int c = 0; c < 3; c++) begin
            #2;
            $display("stall %0d: ov=%b data=%h in_ready=%b", c, out_valid, out_data, in_ready);
            check($sformatf("bp%0d out_data", c),  32'(out_data),  32'hBEEF);
            check($sformatf("bp%0d out_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d in_ready", c),  32'(in_ready),  32'd0);
            if (out_valid && out_ready) xf++;
            @(negedge clock);
        end
        out_ready = 1'b1;
        #2;
        $display("release: ov=%b data=%h in_ready=%b", out_valid, out_data, in_ready);
        check("bp release in_ready", 32'(in_ready), 32'b0010);
        check("bp release out_data", 32'(out_data), 32'hBEEF);
        if (out_valid && out_ready) xf++;
        @(negedge clock);
        in_valid = 4'b0000;
        #2;
        check("bp idle out_valid", 32'(out_valid), 32'd0);
        check("bp idle out_src", 32'(out_src), 32'd2);
        check("bp transfer count", 32'(xf), 32'd1);

        // Wrap/skip: reset, move rr_ptr to 1, then only src0 and src3 compete.
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n   = 1'b1;
        in_valid  = 4'b0001;
        in_last   = 4'b0001;
        in_data   = '0;
        out_ready = 1'b1;
        #2;
        check("wrap setup out_src", 32'(out_src), 32'd0);
        @(negedge clock);

        s0[0] = 16'h0A01; s0[1] = 16'h0A02;
        s3[0] = 16'h3C01; s3[1] = 16'h3C02;
        q0 = {16'h0A01, 16'h0A02};
        q3 = {16'h3C01, 16'h3C02};
        exp_order[0] = 2'd3; exp_order[1] = 2'd0; exp_order[2] = 2'd3; exp_order[3] = 2'd0;
        p0 = 0; p3 = 0; received = 0;
        for (int cyc = 0; cyc < 40 && received < 4; cyc++) begin
            in_valid  = {p3 < 2, 1'b0, 1'b0, p0 < 2};
            in_last   = 4'b1001;
            in_data   = '0;
            if (p0 < 2) in_data[0*DW +: DW] = s0[p0];
            if (p3 < 2) in_data[3*DW +: DW] = s3[p3];
            out_ready = ((cyc % 3) != 1);
            #2;
            if (out_valid && out_ready) begin
                $display("sb beat %0d: src=%0d data=%h", received, out_src, out_data);
                check($sformatf("sb order%0d", received), 32'(out_src), 32'(exp_order[received]));
                if (out_src == 2'd0 && q0.size() > 0) begin
                    check($sformatf("sb data src0 beat%0d", p0), 32'(out_data), 32'(q0.pop_front()));
                    p0++;
                end else if (out_src == 2'd3 && q3.size() > 0) begin
                    check($sformatf("sb data src3 beat%0d", p3), 32'(out_data), 32'(q3.pop_front()));
                    p3++;
                end else begin
                    total++;
                    bad++;
                    $display("FAIL sb unexpected source: got %0d expected 0 or 3", out_src);
                end
                received++;
            end
            @(negedge clock);
        end
        check("sb beats received", 32'(received), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
